// File: rtl/des_round_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_sequencer
//
// Paces the DES datapath one round at a time so a person can watch the cipher
// progress on the board. The slow square wave from the clock divider is
// synchronized into the inClock domain and edge-detected into a one-cycle
// tick. Each run issues one load strobe, ROUNDS round strobes (each with its
// round index) and one done pulse. In auto mode a run advances on slow ticks,
// in manual mode it advances on step pulses.
//
// Parameters
//   ROUNDS      : round strobes per run (2..16)
//   SYNC_STAGES : synchronizer flops on slowClock (>= 2)
//
// Ports
//   inClock   in  : system clock
//   clear     in  : synchronous active-high reset
//   slowClock in  : divider output, asynchronous level
//   start     in  : one-cycle pulse, begins a run when idle
//   mode      in  : 0 = auto (slow tick), 1 = manual (step); sampled on start
//   step      in  : one-cycle manual advance pulse
//   loadEn    out : one-cycle strobe, datapath loads plaintext/key
//   roundEn   out : one-cycle strobe, datapath executes round roundIdx
//   roundIdx  out : current round number, 0..ROUNDS-1
//   busy      out : high from LOAD through FINISH
//   done      out : one-cycle pulse after the last round
//   tick      out : edge-detected slow tick (debug)
// -----------------------------------------------------------------------------
module des_round_sequencer #(
  parameter int ROUNDS      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       inClock,
  input  logic       clear,
  input  logic       slowClock,
  input  logic       start,
  input  logic       mode,
  input  logic       step,
  output logic       loadEn,
  output logic       roundEn,
  output logic [3:0] roundIdx,
  output logic       busy,
  output logic       done,
  output logic       tick
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    ROUND,
    FINISH
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   history;
  logic                   tick_q;
  logic                   mode_q;
  logic                   mode_next;
  logic                   pending;
  logic                   pending_next;
  logic [3:0]             round_idx;
  logic [3:0]             round_idx_next;
  logic                   advance;
  logic                   last_round;

  // Slow-clock synchronizer, history flop and registered rising-edge detect.
  // The chain is cleared too, so a slowClock held high through reset shows up
  // as exactly one tick after release.
  always_ff @(posedge inClock) begin
    if (clear) begin
      sync_chain <= '0;
      history    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], slowClock};
      history    <= sync_chain[SYNC_STAGES-1];
      tick_q     <= sync_chain[SYNC_STAGES-1] & ~history;
    end
  end

  // Only the source chosen at start counts; the other one is ignored for the
  // whole run.
  assign advance    = mode_q ? step : tick_q;
  assign last_round = (round_idx == LAST_IDX);

  // State, latched mode, pending flag and round index.
  always_ff @(posedge inClock) begin
    if (clear) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      pending   <= 1'b0;
      round_idx <= 4'd0;
    end else begin
      state     <= state_next;
      mode_q    <= mode_next;
      pending   <= pending_next;
      round_idx <= round_idx_next;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_next     = state;
    mode_next      = mode_q;
    pending_next   = pending;
    round_idx_next = round_idx;
    loadEn         = 1'b0;
    roundEn        = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // An advance event in the same cycle as start is discarded.
        if (start) begin
          state_next     = LOAD;
          mode_next      = mode;
          round_idx_next = 4'd0;
          pending_next   = 1'b0;
        end
      end

      LOAD: begin
        loadEn     = 1'b1;
        state_next = WAIT;
        if (advance) begin
          pending_next = 1'b1;
        end
      end

      WAIT: begin
        if (advance || pending) begin
          state_next = ROUND;
        end
        // A stored event is consumed first; a live event arriving alongside
        // it takes its place in the one-deep flag.
        pending_next = pending & advance;
      end

      ROUND: begin
        roundEn = 1'b1;
        // Setting an already-set flag drops the extra event.
        if (advance) begin
          pending_next = 1'b1;
        end
        if (last_round) begin
          state_next = FINISH;
        end else begin
          round_idx_next = round_idx + 4'd1;
          state_next     = WAIT;
        end
      end

      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
        if (advance) begin
          pending_next = 1'b1;
        end
      end

      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign roundIdx = round_idx;
  assign tick     = tick_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_round_sequencer
//
// Bench for des_round_sequencer. The stimulus process pushes the expected
// strobes (kind, round index, cycle) onto a scoreboard as it drives each run;
// a monitor pops and compares them whenever the DUT raises a strobe.
// -----------------------------------------------------------------------------
module tb_des_round_sequencer;

  localparam int ROUNDS = 16;
  localparam int K_LOAD  = 0;
  localparam int K_ROUND = 1;
  localparam int K_DONE  = 2;

  logic       inClock;
  logic       clear;
  logic       slowClock;
  logic       start;
  logic       mode;
  logic       step;
  logic       loadEn;
  logic       roundEn;
  logic [3:0] roundIdx;
  logic       busy;
  logic       done;
  logic       tick;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } exp_t;

  exp_t sb[$];

  int  n_run   = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  slow_on = 1'b0;
  int  slow_phase = 0;
  bit  mon_en  = 1'b0;
  bit  prev_done = 1'b0;

  des_round_sequencer #(
    .ROUNDS     (ROUNDS),
    .SYNC_STAGES(2)
  ) dut (
    .inClock  (inClock),
    .clear    (clear),
    .slowClock(slowClock),
    .start    (start),
    .mode     (mode),
    .step     (step),
    .loadEn   (loadEn),
    .roundEn  (roundEn),
    .roundIdx (roundIdx),
    .busy     (busy),
    .done     (done),
    .tick     (tick)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  always @(posedge inClock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int k, input int i, input int c);
    exp_t e;
    e.kind = k;
    e.idx  = i;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Moves to the next falling edge, drops one-cycle pulses and, when enabled,
  // drives slowClock as a square wave of period 20 for the coming edge.
  task automatic next_cycle();
    @(negedge inClock);
    start = 1'b0;
    step  = 1'b0;
    if (slow_on) slowClock = (((cyc + 1 - slow_phase) / 10) % 2) != 0;
  endtask

  // One manual round: step in WAIT, round strobe on the following cycle.
  task automatic manual_round(input int idx, input bit busy_start);
    next_cycle();
    step = 1'b1;
    push_exp(K_ROUND, idx, cyc + 1);
    if (idx == ROUNDS - 1) push_exp(K_DONE, ROUNDS - 1, cyc + 2);
    next_cycle();
    if (busy_start) start = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  // Strobe monitor / scoreboard checker.
  always @(negedge inClock) begin
    if (mon_en) begin
      exp_t e;
      int   kind;
      if (prev_done) chk("busy_after_done", busy, 0);
      prev_done <= done;
      if (loadEn || roundEn || done) begin
        chk("strobe_onehot", int'(loadEn) + int'(roundEn) + int'(done), 1);
        kind = loadEn ? K_LOAD : (roundEn ? K_ROUND : K_DONE);
        chk("busy_with_strobe", busy, 1);
        if (sb.size() == 0) begin
          chk("strobe_expected", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("strobe_kind", kind, e.kind);
          chk("strobe_idx", roundIdx, e.idx);
          chk("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    clear     = 1'b1;
    slowClock = 1'b1;
    start     = 1'b0;
    step      = 1'b0;
    mode      = 1'b0;

    // Reset with slowClock held high.
    repeat (3) next_cycle();
    chk("rst_loadEn", loadEn, 0);
    chk("rst_roundEn", roundEn, 0);
    chk("rst_roundIdx", roundIdx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    clear = 1'b0;
    n = cyc;
    repeat (8) begin
      next_cycle();
      chk("tick_after_reset", tick, cyc == n + 3);
      chk("no_load_after_reset", loadEn, 0);
    end
    slowClock = 1'b0;
    mon_en    = 1'b1;
    repeat (6) next_cycle();

    // Auto run, slowClock toggling every 10 cycles.
    next_cycle();
    n0         = cyc;
    slow_phase = n0;
    slow_on    = 1'b1;
    repeat (5) next_cycle();
    start = 1'b1;
    mode  = 1'b0;
    push_exp(K_LOAD, 0, n0 + 6);
    for (int k = 0; k < ROUNDS; k++) push_exp(K_ROUND, k, n0 + 13 + 20 * k);
    push_exp(K_DONE, ROUNDS - 1, n0 + 13 + 20 * (ROUNDS - 1) + 1);
    while (cyc < n0 + 320) begin
      next_cycle();
      chk("tick_auto", tick, (cyc - n0 >= 12) && ((cyc - n0 - 12) % 20 == 0));
    end

    // Manual run with the slow clock still running; step during LOAD pends.
    next_cycle();
    start = 1'b1;
    mode  = 1'b1;
    push_exp(K_LOAD, 0, cyc + 1);
    next_cycle();
    step = 1'b1;
    push_exp(K_ROUND, 0, cyc + 2);
    next_cycle();
    next_cycle();
    // Three consecutive steps from the round-0 cycle: two rounds, one dropped.
    step = 1'b1;
    push_exp(K_ROUND, 1, cyc + 2);
    push_exp(K_ROUND, 2, cyc + 4);
    next_cycle();
    step = 1'b1;
    next_cycle();
    step = 1'b1;
    repeat (30) next_cycle();
    chk("overflow_idx", roundIdx, 3);
    for (int i = 3; i < ROUNDS; i++) manual_round(i, i == 5);
    repeat (6) next_cycle();
    chk("idle_busy", busy, 0);
    chk("idle_hold_idx", roundIdx, ROUNDS - 1);
    chk("idle_done", done, 0);

    // Abort in WAIT at round index 7.
    next_cycle();
    start = 1'b1;
    mode  = 1'b1;
    push_exp(K_LOAD, 0, cyc + 1);
    next_cycle();
    for (int i = 0; i < 7; i++) manual_round(i, 1'b0);
    chk("pre_abort_idx", roundIdx, 7);
    chk("pre_abort_busy", busy, 1);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_idx", roundIdx, 0);
    chk("abort_strobes", {loadEn, roundEn, done}, 0);
    repeat (3) next_cycle();

    // Clean manual run after the abort.
    next_cycle();
    start = 1'b1;
    mode  = 1'b1;
    push_exp(K_LOAD, 0, cyc + 1);
    next_cycle();
    for (int i = 0; i < ROUNDS; i++) manual_round(i, 1'b0);
    repeat (5) next_cycle();
    chk("sb_empty", sb.size(), 0);
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
